// File: rtl/uart_tx_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_tx_sequencer_if                                             |
// | Purpose  : Producer-side bus of the UART transmit sequencer. Each requester |
// |            holds req_valid_in/req_data_in until it sees its req_ack_out bit.|
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface uart_tx_sequencer_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]   req_valid_in;
  logic [8*NUM_REQ-1:0] req_data_in;
  logic [NUM_REQ-1:0]   req_ack_out;

  // Producers drive the request side and watch the acknowledge.
  modport master (
    output req_valid_in,
    output req_data_in,
    input  req_ack_out
  );

  // The sequencer samples requests and returns the acknowledge.
  modport slave (
    input  req_valid_in,
    input  req_data_in,
    output req_ack_out
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_tx_sequencer                                                |
// | Purpose  : Round-robin arbiter feeding a byte FIFO, drained by an FSM that  |
// |            strobes each byte into a shared UART transmitter and tracks its  |
// |            ready line through the frame.                                    |
// | Options  : UART_TX_SEQ_TIMEOUT_EN adds the accept timeout on WAIT_ACC.      |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module uart_tx_sequencer #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int WR_PULSE   = 2,
  parameter int ACC_TMO    = 64
) (
  input  logic                        clk_in,
  input  logic                        n_reset_in,
  input  logic                        enable_in,
  uart_tx_sequencer_if.slave          bus,
  input  logic                        tx_rdy_in,
  output logic                        tx_n_wr_out,
  output logic [7:0]                  tx_data_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out,
  output logic                        busy_out,
  output logic                        timeout_out
);
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam int c_rr_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_pw_w  = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_ACC  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_rr_w-1:0]  r_rr_ptr;
  logic               r_arb_en;
  logic [c_pw_w-1:0]  r_pulse_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_can_grant;
  logic               w_push;
  logic               w_pop;
  logic               w_tmo_hit;
  logic               w_to_idle;
  logic               w_busy_next;
  logic [c_rr_w-1:0]  w_gnt_idx;
  logic [c_rr_w-1:0]  w_cand;
  logic [NUM_REQ-1:0] w_ack;
  logic [7:0]         w_push_data;
  logic [c_cnt_w-1:0] w_count_next;

  assign w_full      = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  // r_arb_en keeps acks off until the first clock after reset release.
  assign w_can_grant = r_arb_en && enable_in && !w_full;
  assign w_pop       = (r_state == S_IDLE) && enable_in && !w_empty && tx_rdy_in;

  // Round-robin search: first valid requester at or after the RR pointer.
  always_comb begin
    w_push    = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_ack     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = c_rr_w'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (w_can_grant && !w_push && bus.req_valid_in[w_cand]) begin
        w_push    = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_push) begin
      w_ack[w_gnt_idx] = 1'b1;
    end
  end

  assign bus.req_ack_out = w_ack;
  assign w_push_data     = bus.req_data_in[{w_gnt_idx, 3'b000} +: 8];

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cnt_w'(1);
    end
  end

`ifdef UART_TX_SEQ_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(ACC_TMO + 1);
  logic [c_tmo_w-1:0] r_acc_cnt;

  assign w_tmo_hit = (r_state == S_WAIT_ACC) && tx_rdy_in &&
                     (r_acc_cnt == c_tmo_w'(ACC_TMO - 1));

  // Count cycles spent waiting for the transmitter to accept; sticky flag on expiry.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_acc_cnt   <= '0;
      timeout_out <= 1'b0;
    end else begin
      if (r_state == S_WAIT_ACC) begin
        r_acc_cnt <= r_acc_cnt + c_tmo_w'(1);
      end else begin
        r_acc_cnt <= '0;
      end
      if (w_tmo_hit) begin
        timeout_out <= 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(ACC_TMO);
  assign w_tmo_hit    = 1'b0;
  assign timeout_out  = 1'b0;
`endif

  assign w_to_idle   = ((r_state == S_WAIT_DONE) && tx_rdy_in) || w_tmo_hit;
  assign w_busy_next = ((r_state != S_IDLE) && !w_to_idle) || w_pop || (w_count_next != '0);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // FIFO pointers, occupancy, arbitration pointer and busy flag.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_arb_en <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
      busy_out <= 1'b0;
    end else begin
      r_arb_en <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        r_rr_ptr <= (w_gnt_idx == c_rr_w'(NUM_REQ - 1)) ? '0 : w_gnt_idx + c_rr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count  <= w_count_next;
      busy_out <= w_busy_next;
    end
  end

  assign fifo_count_out = r_count;

  // Launch sequencer: pop, set up data, strobe, then follow tx_rdy_in through the frame.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_state     <= S_IDLE;
      tx_n_wr_out <= 1'b1;
      tx_data_out <= 8'h00;
      r_pulse_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            tx_data_out <= r_mem[r_rd_ptr];
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_n_wr_out <= 1'b0;
          r_pulse_cnt <= '0;
          r_state     <= S_STROBE;
        end
        S_STROBE: begin
          if (r_pulse_cnt == c_pw_w'(WR_PULSE - 1)) begin
            tx_n_wr_out <= 1'b1;
            r_state     <= S_WAIT_ACC;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + c_pw_w'(1);
          end
        end
        S_WAIT_ACC: begin
          if (!tx_rdy_in) begin
            r_state <= S_WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_rdy_in) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          tx_n_wr_out <= 1'b1;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_sequencer                                             |
// | Purpose  : Self-checking bench for uart_tx_sequencer with a simple          |
// |            transmitter model and a byte scoreboard.                         |
// | Options  : UART_TX_SEQ_TIMEOUT_EN enables the accept-timeout sequence.      |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_sequencer;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       enable = 1'b1;
  logic       tx_rdy;
  logic       tx_n_wr;
  logic [7:0] tx_data;
  logic [3:0] fifo_count;
  logic       busy;
  logic       timeout;

  logic       tx_hold = 1'b0;
  logic       tx_stuck = 1'b0;
  logic [7:0] sb [$];
  int         n_chk = 0;
  int         n_err = 0;

  typedef struct {
    logic       en;
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_ack;
  } vec_t;

  uart_tx_sequencer_if #(.NUM_REQ(2)) bus ();

  uart_tx_sequencer #(
    .NUM_REQ(2), .FIFO_DEPTH(8), .WR_PULSE(2), .ACC_TMO(64)
  ) dut (
    .clk_in(clk), .n_reset_in(n_reset), .enable_in(enable), .bus(bus),
    .tx_rdy_in(tx_rdy), .tx_n_wr_out(tx_n_wr), .tx_data_out(tx_data),
    .fifo_count_out(fifo_count), .busy_out(busy), .timeout_out(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!(busy == 1'b0 && tx_rdy == 1'b1 && sb.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(n < 300), 32'd1);
  endtask

  // Transmitter model: checks each strobed byte against the scoreboard, then
  // drops ready for a short frame once the strobe ends.
  initial begin : tx_model
    logic       prev_nwr;
    int         low_cnt;
    int         frame_cnt;
    logic [7:0] strobe_data;
    prev_nwr = 1'b1; low_cnt = 0; frame_cnt = 0; strobe_data = 8'h00;
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_n_wr == 1'b0) begin
        if (prev_nwr) begin
          strobe_data = tx_data;
          if (sb.size() == 0) chk("tx_byte_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
          else chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
          low_cnt = 1;
        end else begin
          low_cnt++;
        end
      end else if (!prev_nwr) begin
        chk("wr_pulse_width", 32'(low_cnt), 32'd2);
        chk("tx_data_hold", 32'(tx_data), 32'(strobe_data));
        if (!tx_stuck) frame_cnt = 4;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
      end
      prev_nwr = tx_n_wr;
      tx_rdy = !tx_hold && (frame_cnt == 0);
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       tbl [8];
    logic [7:0] pa [2];
    logic [7:0] pb [2];
    logic [7:0] rr_exp [4];
    logic [1:0] rr_ack [4];
    int         ia, ib, k, nlow;

    tbl[0] = '{1'b1, 2'b01, 8'h31, 8'h00, 2'b01};
    tbl[1] = '{1'b1, 2'b00, 8'h00, 8'h00, 2'b00};
    tbl[2] = '{1'b1, 2'b10, 8'h00, 8'h42, 2'b10};
    tbl[3] = '{1'b1, 2'b11, 8'h53, 8'h64, 2'b01};
    tbl[4] = '{1'b1, 2'b10, 8'h00, 8'h64, 2'b10};
    tbl[5] = '{1'b0, 2'b01, 8'h97, 8'h00, 2'b00};
    tbl[6] = '{1'b1, 2'b01, 8'h97, 8'h00, 2'b01};
    tbl[7] = '{1'b1, 2'b10, 8'h00, 8'hA8, 2'b10};
    pa[0] = 8'hA0; pa[1] = 8'hA1; pb[0] = 8'hB0; pb[1] = 8'hB1;
    rr_exp[0] = 8'hA0; rr_exp[1] = 8'hB0; rr_exp[2] = 8'hA1; rr_exp[3] = 8'hB1;
    rr_ack[0] = 2'b01; rr_ack[1] = 2'b10; rr_ack[2] = 2'b01; rr_ack[3] = 2'b10;

    // Reset with both requesters pending.
    bus.req_valid_in = 2'b11;
    bus.req_data_in  = 16'h2211;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.req_ack_out), 32'd0);
    chk("rst_nwr", 32'(tx_n_wr), 32'd1);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    step();
    n_reset = 1'b1;
    step();
    @(negedge clk);
    chk("rst_first_ack", 32'(bus.req_ack_out), 32'd1);
    sb.push_back(8'h11);
    step();
    bus.req_valid_in = 2'b00;
    wait_idle("reset");

    // Single byte: launch latency and strobe shape.
    step();
    bus.req_valid_in = 2'b01;
    bus.req_data_in  = 16'h0075;
    @(negedge clk);
    chk("single_ack", 32'(bus.req_ack_out), 32'd1);
    sb.push_back(8'h75);
    step();
    bus.req_valid_in = 2'b00;
    @(negedge clk);
    chk("single_count", 32'(fifo_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_nwr_e0", 32'(tx_n_wr), 32'd1);
    @(negedge clk);
    chk("single_nwr_e1", 32'(tx_n_wr), 32'd1);
    chk("single_data_e1", 32'(tx_data), 32'h75);
    @(negedge clk);
    chk("single_nwr_e2", 32'(tx_n_wr), 32'd0);
    @(negedge clk);
    chk("single_nwr_e3", 32'(tx_n_wr), 32'd0);
    @(negedge clk);
    chk("single_nwr_e4", 32'(tx_n_wr), 32'd1);
    wait_idle("single");

    // Table of arbiter vectors, one per cycle.
    for (int i = 0; i < 8; i++) begin
      step();
      enable           = tbl[i].en;
      bus.req_valid_in = tbl[i].valid;
      bus.req_data_in  = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i), 32'(bus.req_ack_out), 32'(tbl[i].exp_ack));
      if (tbl[i].exp_ack[0]) sb.push_back(tbl[i].d0);
      if (tbl[i].exp_ack[1]) sb.push_back(tbl[i].d1);
    end
    step();
    bus.req_valid_in = 2'b00;
    enable = 1'b1;
    wait_idle("table");

    // Round robin with both requesters holding valid.
    ia = 0; ib = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      bus.req_valid_in = {1'(ib < 2), 1'(ia < 2)};
      bus.req_data_in  = {(ib < 2) ? pb[ib] : 8'h00, (ia < 2) ? pa[ia] : 8'h00};
      @(negedge clk);
      chk($sformatf("rr%0d_ack", c), 32'(bus.req_ack_out), 32'(rr_ack[c]));
      sb.push_back(rr_exp[c]);
      if (bus.req_ack_out[0]) ia++;
      if (bus.req_ack_out[1]) ib++;
    end
    step();
    bus.req_valid_in = 2'b00;
    wait_idle("rr");

    // FIFO full with the transmitter busy.
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      bus.req_valid_in = 2'b01;
      bus.req_data_in  = {8'h00, 8'hC0 + 8'(k)};
      @(negedge clk);
      chk($sformatf("full%0d_ack", c), 32'(bus.req_ack_out), (c < 8) ? 32'd1 : 32'd0);
      if (c < 8) sb.push_back(8'hC0 + 8'(c));
      if (bus.req_ack_out[0]) k++;
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_busy", 32'(busy), 32'd1);
    tx_hold = 1'b0;
    for (int c = 0; c < 80 && k < 10; c++) begin
      step();
      bus.req_valid_in = 2'b01;
      bus.req_data_in  = {8'h00, 8'hC0 + 8'(k)};
      @(negedge clk);
      if (bus.req_ack_out[0]) begin
        sb.push_back(8'hC0 + 8'(k));
        k++;
      end
    end
    chk("full_resume_acks", 32'(k), 32'd10);
    step();
    bus.req_valid_in = 2'b00;
    wait_idle("full");

    // Enable dropped during WAIT_DONE.
    for (int c = 0; c < 2; c++) begin
      step();
      bus.req_valid_in = 2'b01;
      bus.req_data_in  = {8'h00, 8'hE1 + 8'(c)};
      @(negedge clk);
      chk($sformatf("en%0d_ack", c), 32'(bus.req_ack_out), 32'd1);
      sb.push_back(8'hE1 + 8'(c));
    end
    step();
    bus.req_valid_in = 2'b00;
    k = 0;
    @(negedge clk);
    while (tx_rdy == 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("en_frame_started", 32'(k < 50), 32'd1);
    step();
    enable = 1'b0;
    nlow = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_n_wr == 1'b0) nlow++;
    end
    chk("en_no_strobe", 32'(nlow), 32'd0);
    chk("en_count_held", 32'(fifo_count), 32'd1);
    chk("en_busy_held", 32'(busy), 32'd1);
    step();
    enable = 1'b1;
    wait_idle("enable");

`ifdef UART_TX_SEQ_TIMEOUT_EN
    // Transmitter never accepts the strobe.
    tx_stuck = 1'b1;
    step();
    bus.req_valid_in = 2'b01;
    bus.req_data_in  = 16'h00F5;
    @(negedge clk);
    chk("tmo_ack", 32'(bus.req_ack_out), 32'd1);
    sb.push_back(8'hF5);
    step();
    bus.req_valid_in = 2'b00;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("tmo_early", 32'(timeout), 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("tmo_set", 32'(timeout), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    tx_stuck = 1'b0;
    step();
    bus.req_valid_in = 2'b01;
    bus.req_data_in  = 16'h00F6;
    @(negedge clk);
    chk("tmo_next_ack", 32'(bus.req_ack_out), 32'd1);
    sb.push_back(8'hF6);
    step();
    bus.req_valid_in = 2'b00;
    wait_idle("timeout");
    chk("tmo_sticky", 32'(timeout), 32'd1);
`else
    chk("timeout_tied", 32'(timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
